// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end: FSM states, read sub-phases,
// RAM command opcodes and default word widths.
package spi_pkg;

  localparam int RX_WIDTH_DFLT = 10;
  localparam int TX_WIDTH_DFLT = 8;

  // Opcodes carried in rx_data[9:8]; decoded by the RAM, not by the slave.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_t;

  // Progress of a READ_DATA frame once the command word has been received.
  typedef enum logic [1:0] {
    RD_RX    = 2'd0,
    RD_WAIT  = 2'd1,
    RD_SHIFT = 2'd2,
    RD_DONE  = 2'd3
  } rd_phase_t;

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserialises MOSI frames into command words for the RAM and
// serialises RAM read data back out on MISO after a read-data command.
module spi_slave
  import spi_pkg::*;
#(
  parameter int RX_WIDTH = RX_WIDTH_DFLT,
  parameter int TX_WIDTH = TX_WIDTH_DFLT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid
);

  localparam logic [3:0] RX_LAST = 4'(RX_WIDTH - 1);
  localparam logic [3:0] RX_FULL = 4'(RX_WIDTH);
  localparam logic [3:0] TX_LAST = 4'(TX_WIDTH - 1);
  localparam logic [3:0] TX_FULL = 4'(TX_WIDTH);

  spi_state_t            state, state_nxt;
  rd_phase_t             rd_phase;
  logic [3:0]            bit_cnt;
  logic [3:0]            tx_cnt;
  logic [TX_WIDTH-1:0]   tx_shift;
  logic                  rd_addr_seen;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        // The decision bit only steers the FSM; it is never stored.
        CHK_CMD: begin
          if (!MOSI)             state_nxt = WRITE;
          else if (rd_addr_seen) state_nxt = READ_DATA;
          else                   state_nxt = READ_ADD;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      tx_cnt       <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      tx_shift     <= '0;
      rd_addr_seen <= 1'b0;
      rd_phase     <= RD_RX;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        // Abort or idle: drop any partial frame; rd_addr_seen is kept.
        bit_cnt  <= '0;
        tx_cnt   <= '0;
        MISO     <= 1'b0;
        rd_phase <= RD_RX;
      end else begin
        case (state)
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt < RX_FULL) begin
              rx_data <= {rx_data[RX_WIDTH-2:0], MOSI};
              bit_cnt <= sat_inc(bit_cnt);
              if (bit_cnt == RX_LAST) begin
                rx_valid <= 1'b1;
                if (state == READ_ADD) rd_addr_seen <= 1'b1;
              end
            end else if (state == READ_DATA) begin
              case (rd_phase)
                // Skip the rx_valid cycle: tx_valid may still be high from an older read.
                RD_RX:   rd_phase <= RD_WAIT;
                RD_WAIT: begin
                  if (tx_valid) begin
                    MISO     <= tx_data[TX_WIDTH-1];
                    tx_shift <= {tx_data[TX_WIDTH-2:0], 1'b0};
                    tx_cnt   <= 4'd1;
                    rd_phase <= RD_SHIFT;
                  end
                end
                RD_SHIFT: begin
                  if (tx_cnt == TX_FULL) begin
                    MISO     <= 1'b0;
                    rd_phase <= RD_DONE;
                  end else begin
                    MISO     <= tx_shift[TX_WIDTH-1];
                    tx_shift <= {tx_shift[TX_WIDTH-2:0], 1'b0};
                    tx_cnt   <= sat_inc(tx_cnt);
                    if (tx_cnt == TX_LAST) rd_addr_seen <= 1'b0;
                  end
                end
                default: MISO <= 1'b0;
              endcase
            end
          end
          default: begin
            bit_cnt  <= '0;
            tx_cnt   <= '0;
            MISO     <= 1'b0;
            rd_phase <= RD_RX;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave front end that sits directly upstream of the single-port RAM. It deserialises master MOSI frames into 10-bit command words (rx_data/rx_valid) for the RAM. On a read-data command it serialises the RAM's 8-bit response (tx_data/tx_valid) back out on MISO. Single clock domain: SPI bit clock is clk.

Parameters:
RX_WIDTH, 10, command word width (2-bit opcode + 8-bit payload); fixed by the RAM interface.
TX_WIDTH, 8, read-data width returned on MISO.

Ports:
clk  input  1  system/SPI bit clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
SS_n  input  1  slave select, active low; frames a transaction
MOSI  input  1  serial data from master, MSB first, sampled on rising clk
MISO  output  1  serial data to master, MSB first
rx_data  output  RX_WIDTH  assembled command word to RAM din
rx_valid  output  1  one-cycle strobe, rx_data complete
tx_data  input  TX_WIDTH  read data from RAM dout
tx_valid  input  1  RAM read data valid (level; RAM holds it until next command)

Behaviour:
- Reset is asynchronous and active-low on rst_n. It clears state to IDLE, bit counter to 0, rx_data to 0, rx_valid to 0, MISO to 0, tx shift register to 0 and rd_addr_seen to 0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Encoding lives in the package.
- IDLE: SS_n sampled 0 -> CHK_CMD. Otherwise stay in IDLE.
- CHK_CMD: MOSI sampled this cycle is the decision bit and is not stored.
  - Decision bit 0 -> WRITE.
  - Decision bit 1 with rd_addr_seen=0 -> READ_ADD.
  - Decision bit 1 with rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Next 10 rising edges shift MOSI into rx_data, MSB first (bit 9 first).
  - On the edge sampling bit 0, rx_valid is registered high for exactly one cycle. rx_data is stable during that cycle and holds until the next frame's first shift.
  - Latency: rx_valid is high in the 12th cycle after the IDLE->CHK_CMD edge.
- READ_ADD completion sets rd_addr_seen=1.
- READ_DATA completion clears rd_addr_seen, on the last MISO bit.
- WRITE / READ_ADD after rx_valid: stay in state and ignore MOSI until SS_n=1.
- READ_DATA after rx_valid:
  - Enter wait phase. tx_valid is ignored until the cycle after rx_valid, because RAM tx_valid is sticky from an earlier read.
  - First edge sampling tx_valid=1 in the wait phase loads tx_data. MISO=tx_data[7] from that edge.
  - Each following edge shifts, for 8 MISO bits total.
  - After bit 0, MISO returns to 0 and the state idles in READ_DATA until SS_n=1.
  - No timeout: the block waits for tx_valid indefinitely while SS_n=0.
- SS_n=1 sampled in any state:
  - State -> IDLE on that edge; bit counter cleared; MISO=0; rx_valid=0.
  - A partial frame is discarded with no rx_valid.
  - rd_addr_seen is unchanged, except that an aborted READ_DATA also leaves it unchanged.
- SS_n=1 and the 10th bit on the same edge: the abort wins and no rx_valid is produced.
- The decision bit is not checked against rx_data[9]. A mismatch is passed through unaltered; the RAM decodes rx_data[9:8].
- MISO is 0 whenever not transmitting.
- Bit counter is 4 bits and saturates; no wrap-around within a frame.

Decomposition:
- Package spi_pkg holds:
  - state enum values;
  - opcode constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - RX_WIDTH and TX_WIDTH defaults.
- No sub-module: the FSM, shift-in register, shift-out register and counter form one block.
- Integration wrapper spi_wrapper instantiates spi_slave and the RAM. It is separate and not part of this block.

Test Plan:
- Write address: SS_n low, decision 0, MOSI 10'b00_1010_0101 -> state WRITE; rx_data=10'h0A5 and rx_valid=1 for exactly one cycle, 12 cycles after SS_n fall; MISO stays 0.
- Write data: decision 0, MOSI 10'b01_0011_1100 -> rx_data=10'h13C with a one-cycle rx_valid; rd_addr_seen unchanged (0).
- Read address then read data:
  - Decision 1, MOSI 10'b10_0000_0111 -> READ_ADD, rx_data=10'h207, rd_addr_seen=1.
  - Next frame: decision 1, MOSI 10'b11_0000_0000 -> READ_DATA, rx_valid.
  - Drive tx_data=8'hC3 with tx_valid 2 cycles later -> MISO 1,1,0,0,0,0,1,1 on consecutive cycles, then 0; rd_addr_seen=0.
- Stale tx_valid: hold tx_valid=1 throughout a READ_DATA frame -> no MISO activity before rx_valid; transmission starts only after the post-rx_valid wait phase begins.
- Abort: SS_n rises after 5 data bits of a WRITE frame -> IDLE next edge, no rx_valid, MISO=0. A following full frame with MOSI 10'h0FF yields rx_data=10'h0FF.
- Async reset mid-transmit: rst_n low after 3 MISO bits of 8'hA5, asynchronous to clk -> MISO, rx_valid and rx_data go 0 immediately, state IDLE, rd_addr_seen=0.
